// File: rtl/pulse_train_gen_pkg.sv
// ---------------------------------------------------------------------------
// pulse_train_gen_pkg
//
// Shared definitions for the pulse-train transmitter:
//   - DEF_CNT_W / DEF_NUM_W : default widths of the phase-width and
//                             pulse-count configuration fields
//   - ST_IDLE / ST_HIGH / ST_LOW : FSM state encoding
//   - pt_state_e            : typed view of the state encoding
//   - pt_state_active()     : true for the states in which a train is running
// ---------------------------------------------------------------------------
package pulse_train_gen_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_NUM_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HIGH = ST_HIGH,
        S_LOW  = ST_LOW
    } pt_state_e;

    // A train is in flight whenever the FSM is outside IDLE.
    function automatic logic pt_state_active(input pt_state_e st);
        return (st == S_HIGH) || (st == S_LOW);
    endfunction

endpackage : pulse_train_gen_pkg

// File: rtl/pulse_train_gen_if.sv
// ---------------------------------------------------------------------------
// pulse_train_gen_if
//
// Host-side control and status bundle of the pulse-train transmitter.
//   master : host / register block (drives start, abort and configuration,
//            observes the waveform and status strobes)
//   slave  : pulse_train_gen itself
//
// Signals:
//   start        launch strobe (one cycle)
//   abort        stop an active train
//   high_cycles  high width H (0 treated as 1)
//   low_cycles   low width L  (0 treated as 1)
//   num_pulses   pulse count N (0 = no pulses)
//   sig_out      generated waveform
//   busy         train active
//   done         one-cycle strobe on normal completion
//   rise_stb     first cycle of each high phase
//   fall_stb     first cycle of each low phase
// ---------------------------------------------------------------------------
interface pulse_train_gen_if
    import pulse_train_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
);

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic [NUM_W-1:0] num_pulses;

    logic             sig_out;
    logic             busy;
    logic             done;
    logic             rise_stb;
    logic             fall_stb;

    modport master (
        output start, abort, high_cycles, low_cycles, num_pulses,
        input  sig_out, busy, done, rise_stb, fall_stb
    );

    modport slave (
        input  start, abort, high_cycles, low_cycles, num_pulses,
        output sig_out, busy, done, rise_stb, fall_stb
    );

endinterface : pulse_train_gen_if

// File: rtl/pulse_train_gen_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//
// Loadable CNT_W-bit down-counter that times one phase of the pulse train.
// It is loaded with (width - 1) on the first cycle of a phase and counts
// down while en is high; expire is registered and is high during the cycle
// in which the count sits at zero, i.e. the last cycle of the phase.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   load      load load_val into the counter (takes priority over en)
//   load_val  phase width minus one
//   en        decrement enable
//   expire    registered "count is zero" flag
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expire_q, expire_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
        // Computing the flag from the next count keeps it aligned with the
        // count register without a combinational path to the output.
        expire_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule : phase_timer

// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
//
// Programmable pulse-train transmitter. A start strobe in IDLE latches the
// configuration (H, L, N) and produces N pulses, each H cycles high followed
// by L cycles low. done pulses for one cycle after the last low phase; abort
// returns to IDLE immediately without done or a closing fall strobe.
//
// Ports:
//   clk    system clock (all outputs registered on its rising edge)
//   rst_n  asynchronous active-low reset
//   bus    pulse_train_gen_if.slave: start/abort/configuration in,
//          sig_out/busy/done/rise_stb/fall_stb out
// ---------------------------------------------------------------------------
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_train_gen_if.slave  bus
);

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    pt_state_e        state_q, state_d;
    logic [CNT_W-1:0] high_q, high_d;      // latched H, already clamped >= 1
    logic [CNT_W-1:0] low_q, low_d;        // latched L, already clamped >= 1
    logic [NUM_W-1:0] num_q, num_d;        // latched N
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;

    logic             sig_out_q, sig_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rise_stb_q, rise_stb_d;
    logic             fall_stb_q, fall_stb_d;

    // Phase timer control
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_expire;

    // Configuration as seen on the bus, with zero widths clamped to one
    logic [CNT_W-1:0] high_clamp;
    logic [CNT_W-1:0] low_clamp;
    logic [NUM_W-1:0] pulse_cnt_inc;

    assign high_clamp = (bus.high_cycles == '0) ? CNT_W'(1) : bus.high_cycles;
    assign low_clamp  = (bus.low_cycles  == '0) ? CNT_W'(1) : bus.low_cycles;

    // -----------------------------------------------------------------------
    // Phase timer: one instance, reloaded at the start of every phase
    // -----------------------------------------------------------------------
    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // Outputs default to their idle values so that any path back to IDLE
    // (normal end, abort) produces a clean all-zero output set.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        high_d        = high_q;
        low_d         = low_q;
        num_d         = num_q;
        pulse_cnt_d   = pulse_cnt_q;

        sig_out_d     = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        rise_stb_d    = 1'b0;
        fall_stb_d    = 1'b0;

        tmr_load      = 1'b0;
        tmr_load_val  = '0;
        tmr_en        = 1'b0;

        // Pulse counter is NUM_W wide and only ever reaches N, so a train of
        // 2^NUM_W-1 pulses ends at the all-ones value without wrapping.
        pulse_cnt_inc = pulse_cnt_q + NUM_W'(1);

        case (state_q)
            S_IDLE: begin
                // abort in the same cycle as start drops the start.
                if (bus.start && !bus.abort) begin
                    high_d      = high_clamp;
                    low_d       = low_clamp;
                    num_d       = bus.num_pulses;
                    pulse_cnt_d = '0;
                    if (bus.num_pulses == '0) begin
                        // Empty train: completes immediately, no waveform.
                        done_d = 1'b1;
                    end else begin
                        state_d      = S_HIGH;
                        sig_out_d    = 1'b1;
                        busy_d       = 1'b1;
                        rise_stb_d   = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = high_clamp - CNT_W'(1);
                    end
                end
            end

            S_HIGH: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (tmr_expire) begin
                    state_d      = S_LOW;
                    busy_d       = 1'b1;
                    fall_stb_d   = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = low_q - CNT_W'(1);
                end else begin
                    sig_out_d = 1'b1;
                    busy_d    = 1'b1;
                    tmr_en    = 1'b1;
                end
            end

            S_LOW: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (tmr_expire) begin
                    pulse_cnt_d = pulse_cnt_inc;
                    if (pulse_cnt_inc == num_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = S_HIGH;
                        sig_out_d    = 1'b1;
                        busy_d       = 1'b1;
                        rise_stb_d   = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = high_q - CNT_W'(1);
                    end
                end else begin
                    busy_d = 1'b1;
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            high_q      <= CNT_W'(1);
            low_q       <= CNT_W'(1);
            num_q       <= '0;
            pulse_cnt_q <= '0;
            sig_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rise_stb_q  <= 1'b0;
            fall_stb_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            high_q      <= high_d;
            low_q       <= low_d;
            num_q       <= num_d;
            pulse_cnt_q <= pulse_cnt_d;
            sig_out_q   <= sig_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rise_stb_q  <= rise_stb_d;
            fall_stb_q  <= fall_stb_d;
        end
    end

    assign bus.sig_out  = sig_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rise_stb = rise_stb_q;
    assign bus.fall_stb = fall_stb_q;

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_train_gen
//
// Self-checking bench for pulse_train_gen. Expected outputs per cycle are
// computed arithmetically from (H, L, N, abort cycle) and the cycle index
// since the start strobe; a receive-side edge detector on sig_out is
// checked for edge count and latency against the expected rise strobes.
// ---------------------------------------------------------------------------
module tb_pulse_train_gen;

    logic clk;
    logic rst_n;

    pulse_train_gen_if #(.CNT_W(16), .NUM_W(16)) bus_if ();

    pulse_train_gen #(
        .CNT_W (16),
        .NUM_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive-side detector: two flops on sig_out plus a registered edge flag.
    logic det_s1, det_s2, det_edge;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_s1   <= 1'b0;
            det_s2   <= 1'b0;
            det_edge <= 1'b0;
        end else begin
            det_s1   <= bus_if.sig_out;
            det_s2   <= det_s1;
            det_edge <= det_s1 & ~det_s2;
        end
    end

    int checks_total  = 0;
    int checks_passed = 0;
    int cur_t         = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cur_t, got, exp);
        end
    endtask

    function automatic logic [4:0] outs_now();
        return {bus_if.sig_out, bus_if.busy, bus_if.done, bus_if.rise_stb, bus_if.fall_stb};
    endfunction

    // Expected {sig_out, busy, done, rise_stb, fall_stb} in cycle t after the
    // start strobe (start sampled in cycle 0). h, l are already clamped.
    function automatic logic [4:0] model(input int t, input int h, input int l,
                                         input int n, input int abort_at);
        int p;
        int ph;
        p = h + l;
        if (abort_at > 0 && t > abort_at) return 5'b00000;
        if (n == 0) return (t == 1) ? 5'b00100 : 5'b00000;
        if (t >= 1 && t <= n * p) begin
            ph = (t - 1) % p;
            return {(ph < h), 1'b1, 1'b0, (ph == 0), (ph == h)};
        end
        if (t == n * p + 1) return 5'b00100;
        return 5'b00000;
    endfunction

    task automatic idle_cycles(input int n);
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cur_t = -1;
            check_eq("idle", 32'(outs_now()), 32'h0);
        end
    endtask

    // Drives start in the current cycle and checks every following cycle up
    // to the done cycle (or three cycles past an abort). Returns at the
    // negedge of that last cycle so a caller may start again in it.
    task automatic run_train(input int h_in, input int l_in, input int n_in,
                             input int abort_at, input bit extra_starts,
                             input bit check_edges);
        int h, l, p, last, edge_cnt;
        logic prev1, prev2;
        logic [4:0] exp;
        h = (h_in == 0) ? 1 : h_in;
        l = (l_in == 0) ? 1 : l_in;
        p = h + l;
        last = (abort_at > 0) ? abort_at + 3 : ((n_in == 0) ? 1 : n_in * p + 1);
        edge_cnt = 0;
        prev1 = 1'b0;
        prev2 = 1'b0;

        bus_if.start       = 1'b1;
        bus_if.abort       = 1'b0;
        bus_if.high_cycles = 16'(h_in);
        bus_if.low_cycles  = 16'(l_in);
        bus_if.num_pulses  = 16'(n_in);

        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            cur_t = t;
            exp = model(t, h, l, n_in, abort_at);
            check_eq("outs", 32'(outs_now()), 32'(exp));
            if (det_edge) begin
                check_eq("edge_lat", 32'(prev2), 32'h1);
                edge_cnt++;
            end
            prev2 = prev1;
            prev1 = exp[1];

            bus_if.start = 1'b0;
            bus_if.abort = (t == abort_at);
            if (extra_starts && (t == 3 || t == 6) && t < n_in * p &&
                (abort_at == 0 || t < abort_at))
                bus_if.start = 1'b1;
            if (t < last) begin
                // Mid-train configuration changes must be ignored.
                bus_if.high_cycles = 16'($urandom_range(0, 9));
                bus_if.low_cycles  = 16'($urandom_range(0, 9));
                bus_if.num_pulses  = 16'($urandom_range(0, 20));
            end
        end
        bus_if.abort = 1'b0;
        if (check_edges && abort_at == 0)
            check_eq("edge_cnt", 32'(edge_cnt), 32'(n_in));
        $display("train H=%0d L=%0d N=%0d abort_at=%0d extra_start=%0d edges=%0d",
                 h_in, l_in, n_in, abort_at, extra_starts, edge_cnt);
    endtask

    initial begin
        logic [4:0] exp;
        rst_n              = 1'b0;
        bus_if.start       = 1'b0;
        bus_if.abort       = 1'b0;
        bus_if.high_cycles = '0;
        bus_if.low_cycles  = '0;
        bus_if.num_pulses  = '0;

        repeat (3) @(negedge clk);
        check_eq("reset", 32'(outs_now()), 32'h0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic train
        run_train(3, 2, 4, 0, 1'b0, 1'b1);
        idle_cycles(2);

        // Degenerate configurations
        run_train(0, 0, 2, 0, 1'b0, 1'b1);
        idle_cycles(2);
        run_train(4, 4, 0, 0, 1'b0, 1'b1);
        idle_cycles(2);

        // Abort in the middle of a train
        run_train(5, 5, 3, 8, 1'b0, 1'b0);
        idle_cycles(2);

        // Repeated start while busy, then start in the done cycle
        run_train(3, 2, 4, 0, 1'b1, 1'b1);
        run_train(2, 3, 2, 0, 1'b0, 1'b1);
        idle_cycles(2);

        // start together with abort in IDLE: nothing happens
        bus_if.start       = 1'b1;
        bus_if.abort       = 1'b1;
        bus_if.high_cycles = 16'd2;
        bus_if.low_cycles  = 16'd2;
        bus_if.num_pulses  = 16'd3;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        cur_t = 1;
        check_eq("start_abort", 32'(outs_now()), 32'h0);
        idle_cycles(4);
        $display("start+abort in idle");

        // Asynchronous reset in the middle of a HIGH phase
        bus_if.start       = 1'b1;
        bus_if.high_cycles = 16'd5;
        bus_if.low_cycles  = 16'd3;
        bus_if.num_pulses  = 16'd4;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            cur_t = t;
            bus_if.start = 1'b0;
            exp = model(t, 5, 3, 4, 0);
            check_eq("pre_rst", 32'(outs_now()), 32'(exp));
        end
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", 32'(outs_now()), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("in_rst", 32'(outs_now()), 32'h0);
        end
        rst_n = 1'b1;
        idle_cycles(1);
        run_train(2, 2, 3, 0, 1'b0, 1'b1);
        $display("reset mid-train and restart");
        idle_cycles(1);

        // Random loopback trains
        for (int i = 0; i < 10; i++) begin
            int h, l, n;
            h = $urandom_range(1, 8);
            l = $urandom_range(1, 8);
            n = $urandom_range(1, 16);
            run_train(h, l, n, 0, 1'b0, 1'b1);
            idle_cycles($urandom_range(0, 2));
        end

        // Random trains with aborts, including zero widths
        for (int i = 0; i < 6; i++) begin
            int h, l, n, ab;
            h = $urandom_range(0, 6);
            l = $urandom_range(0, 6);
            n = $urandom_range(1, 6);
            ab = $urandom_range(1, n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l)));
            run_train(h, l, n, ab, 1'b0, 1'b0);
            idle_cycles(1);
        end

        idle_cycles(3);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_pulse_train_gen
